// File: rtl/set_bit_serializer.sv
// rtl/set_bit_serializer.sv - emits the positions of a word's set bits, LSB first, one per beat
module set_bit_serializer #(
    parameter int WIDTH = 16,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic             idx_last_o,
    output logic             idx_val_o,
    input  logic             idx_ready_i,
    output logic             zero_o
);

    typedef enum logic {IDLE, SER} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             ready_q, ready_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] rest;
    logic [IDX_W-1:0] idx;
    logic             last;

    // mask is zero whenever IDLE, so onehot/idx read as zero outside SER
    always_comb begin
        lowest = mask_q & (~mask_q + WIDTH'(1));
        rest   = mask_q & (mask_q - WIDTH'(1));
        last   = (state_q == SER) && (rest == '0);
        idx    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_val_i && ready_q) begin
                    if (data_i == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        mask_d  = data_i;
                        state_d = SER;
                    end
                end
            end
            SER: begin
                if (idx_ready_i) begin
                    mask_d = rest;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // ready is a flop of its own so it stays low through reset and rises on the first edge after release
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ready_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            zero_q  <= zero_d;
        end
    end

    assign data_ready_o = ready_q;
    assign idx_val_o    = (state_q == SER);
    assign idx_o        = idx;
    assign onehot_o     = lowest;
    assign idx_last_o   = last;
    assign zero_o       = zero_q;

endmodule

// File: tb/tb_set_bit_serializer.sv
// tb/tb_set_bit_serializer.sv - directed bench for set_bit_serializer at WIDTH=8 and WIDTH=5
module tb_set_bit_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] data8;
    logic       val8, drdy8, last8, ival8, rdy8, zero8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [4:0] data5;
    logic       val5, drdy5, last5, ival5, rdy5, zero5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    int checks = 0;
    int errors = 0;

    set_bit_serializer #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data8), .data_val_i(val8),
        .data_ready_o(drdy8), .idx_o(idx8), .onehot_o(oh8), .idx_last_o(last8),
        .idx_val_o(ival8), .idx_ready_i(rdy8), .zero_o(zero8)
    );

    set_bit_serializer #(.WIDTH(5)) u_dut5 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(data5), .data_val_i(val5),
        .data_ready_o(drdy5), .idx_o(idx5), .onehot_o(oh5), .idx_last_o(last5),
        .idx_val_o(ival5), .idx_ready_i(rdy5), .zero_o(zero5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++; if (drdy8 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", drdy8); end
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL reset_val: got %0b expected 0", ival8); end
        checks++; if (last8 !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", last8); end
        checks++; if (zero8 !== 1'b0) begin errors++; $display("FAIL reset_zero: got %0b expected 0", zero8); end
        checks++; if (idx8 !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", idx8); end
        checks++; if (oh8 !== 8'h00) begin errors++; $display("FAIL reset_onehot: got %0h expected 0", oh8); end
        checks++; if (drdy5 !== 1'b0) begin errors++; $display("FAIL reset_ready5: got %0b expected 0", drdy5); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b expected 1", drdy8); end
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL reset_release_val: got %0b expected 0", ival8); end
    endtask

    task automatic test_basic();
        logic [2:0] exp_idx[3] = '{3'd2, 3'd5, 3'd7};
        logic [7:0] exp_oh[3]  = '{8'h04, 8'h20, 8'h80};
        checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL basic_ready_pre: got %0b expected 1", drdy8); end
        data8 = 8'hA4; val8 = 1'b1; rdy8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            val8 = 1'b0;
            checks++; if (ival8 !== 1'b1) begin errors++; $display("FAIL basic_val[%0d]: got %0b expected 1", k, ival8); end
            checks++; if (idx8 !== exp_idx[k]) begin errors++; $display("FAIL basic_idx[%0d]: got %0d expected %0d", k, idx8, exp_idx[k]); end
            checks++; if (oh8 !== exp_oh[k]) begin errors++; $display("FAIL basic_onehot[%0d]: got %0h expected %0h", k, oh8, exp_oh[k]); end
            checks++; if (last8 !== (k == 2)) begin errors++; $display("FAIL basic_last[%0d]: got %0b expected %0b", k, last8, k == 2); end
            checks++; if (drdy8 !== 1'b0) begin errors++; $display("FAIL basic_ready_busy[%0d]: got %0b expected 0", k, drdy8); end
        end
        @(negedge clk);
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL basic_val_after: got %0b expected 0", ival8); end
        checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %0b expected 1", drdy8); end
    endtask

    task automatic test_backpressure();
        logic       rdy_seq[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] exp_idx[6] = '{3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd7};
        logic [7:0] exp_oh[6]  = '{8'h04, 8'h20, 8'h20, 8'h20, 8'h20, 8'h80};
        int hs = 0;
        data8 = 8'hA4; val8 = 1'b1; rdy8 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            val8 = 1'b0;
            rdy8 = rdy_seq[c];
            checks++; if (idx8 !== exp_idx[c]) begin errors++; $display("FAIL bp_idx[%0d]: got %0d expected %0d", c, idx8, exp_idx[c]); end
            checks++; if (oh8 !== exp_oh[c]) begin errors++; $display("FAIL bp_onehot[%0d]: got %0h expected %0h", c, oh8, exp_oh[c]); end
            checks++; if (last8 !== (c == 5)) begin errors++; $display("FAIL bp_last[%0d]: got %0b expected %0b", c, last8, c == 5); end
            if (ival8 && rdy8) hs++;
        end
        @(negedge clk);
        rdy8 = 1'b1;
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL bp_val_after: got %0b expected 0", ival8); end
        checks++; if (hs !== 3) begin errors++; $display("FAIL bp_handshakes: got %0d expected 3", hs); end
    endtask

    task automatic test_zero();
        data8 = 8'h00; val8 = 1'b1;
        @(negedge clk);
        val8 = 1'b0;
        checks++; if (zero8 !== 1'b1) begin errors++; $display("FAIL zero_pulse: got %0b expected 1", zero8); end
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL zero_val: got %0b expected 0", ival8); end
        checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", drdy8); end
        @(negedge clk);
        checks++; if (zero8 !== 1'b0) begin errors++; $display("FAIL zero_pulse_end: got %0b expected 0", zero8); end
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL zero_val_after: got %0b expected 0", ival8); end
        data8 = 8'h80; val8 = 1'b1; rdy8 = 1'b1;
        @(negedge clk);
        val8 = 1'b0;
        checks++; if (ival8 !== 1'b1) begin errors++; $display("FAIL msb_val: got %0b expected 1", ival8); end
        checks++; if (idx8 !== 3'd7) begin errors++; $display("FAIL msb_idx: got %0d expected 7", idx8); end
        checks++; if (last8 !== 1'b1) begin errors++; $display("FAIL msb_last: got %0b expected 1", last8); end
        checks++; if (zero8 !== 1'b0) begin errors++; $display("FAIL msb_zero: got %0b expected 0", zero8); end
        @(negedge clk);
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL msb_val_after: got %0b expected 0", ival8); end
    endtask

    task automatic test_all_ones_random();
        int ptr = 0;
        int hs  = 0;
        data8 = 8'hFF; val8 = 1'b1; rdy8 = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (!ival8) begin
                val8 = 1'b0;
                break;
            end
            checks++; if (idx8 !== 3'(ptr)) begin errors++; $display("FAIL ones_idx: got %0d expected %0d", idx8, ptr); end
            checks++; if (last8 !== (ptr == 7)) begin errors++; $display("FAIL ones_last[%0d]: got %0b expected %0b", ptr, last8, ptr == 7); end
            checks++; if (drdy8 !== 1'b0) begin errors++; $display("FAIL ones_ready_busy[%0d]: got %0b expected 0", ptr, drdy8); end
            rdy8 = 1'($urandom_range(0, 1));
            if (rdy8) begin
                ptr++;
                hs++;
            end
        end
        val8 = 1'b0;
        rdy8 = 1'b1;
        checks++; if (hs !== 8) begin errors++; $display("FAIL ones_handshakes: got %0d expected 8", hs); end
        checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL ones_ready_after: got %0b expected 1", drdy8); end
        @(negedge clk);
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL ones_no_second_word: got %0b expected 0", ival8); end
    endtask

    task automatic test_reset_mid();
        data8 = 8'hFF; val8 = 1'b1; rdy8 = 1'b1;
        @(negedge clk);
        val8 = 1'b0;
        @(negedge clk);
        checks++; if (idx8 !== 3'd1) begin errors++; $display("FAIL rstmid_beat2_idx: got %0d expected 1", idx8); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL rstmid_val_async: got %0b expected 0", ival8); end
        checks++; if (drdy8 !== 1'b0) begin errors++; $display("FAIL rstmid_ready_async: got %0b expected 0", drdy8); end
        checks++; if (oh8 !== 8'h00) begin errors++; $display("FAIL rstmid_onehot_async: got %0h expected 0", oh8); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL rstmid_residual[%0d]: got %0b expected 0", c, ival8); end
            checks++; if (drdy8 !== 1'b1) begin errors++; $display("FAIL rstmid_ready[%0d]: got %0b expected 1", c, drdy8); end
        end
        data8 = 8'h01; val8 = 1'b1;
        @(negedge clk);
        val8 = 1'b0;
        checks++; if (ival8 !== 1'b1) begin errors++; $display("FAIL rstmid_new_val: got %0b expected 1", ival8); end
        checks++; if (idx8 !== 3'd0) begin errors++; $display("FAIL rstmid_new_idx: got %0d expected 0", idx8); end
        checks++; if (oh8 !== 8'h01) begin errors++; $display("FAIL rstmid_new_onehot: got %0h expected 1", oh8); end
        checks++; if (last8 !== 1'b1) begin errors++; $display("FAIL rstmid_new_last: got %0b expected 1", last8); end
        @(negedge clk);
        checks++; if (ival8 !== 1'b0) begin errors++; $display("FAIL rstmid_new_done: got %0b expected 0", ival8); end
    endtask

    task automatic test_width5();
        logic [2:0] exp_idx[2] = '{3'd0, 3'd4};
        logic [4:0] exp_oh[2]  = '{5'h01, 5'h10};
        checks++; if (drdy5 !== 1'b1) begin errors++; $display("FAIL w5_ready_pre: got %0b expected 1", drdy5); end
        data5 = 5'b10001; val5 = 1'b1; rdy5 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            val5 = 1'b0;
            checks++; if (ival5 !== 1'b1) begin errors++; $display("FAIL w5_val[%0d]: got %0b expected 1", k, ival5); end
            checks++; if (idx5 !== exp_idx[k]) begin errors++; $display("FAIL w5_idx[%0d]: got %0d expected %0d", k, idx5, exp_idx[k]); end
            checks++; if (oh5 !== exp_oh[k]) begin errors++; $display("FAIL w5_onehot[%0d]: got %0h expected %0h", k, oh5, exp_oh[k]); end
            checks++; if (last5 !== (k == 1)) begin errors++; $display("FAIL w5_last[%0d]: got %0b expected %0b", k, last5, k == 1); end
        end
        @(negedge clk);
        checks++; if (ival5 !== 1'b0) begin errors++; $display("FAIL w5_val_after: got %0b expected 0", ival5); end
        checks++; if (drdy5 !== 1'b1) begin errors++; $display("FAIL w5_ready_after: got %0b expected 1", drdy5); end
    endtask

    initial begin
        rst_n = 1'b0;
        data8 = '0; val8 = 1'b0; rdy8 = 1'b0;
        data5 = '0; val5 = 1'b0; rdy5 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_all_ones_random();
        test_reset_mid();
        test_width5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
- Consumer-side companion to the team's priority encoder.
- Accepts a WIDTH-bit word and emits the positions of its set bits, one per beat, from LSB to MSB.
- Each beat carries a binary index and a one-hot vector, under a valid/ready handshake.
- Feeds downstream blocks that must service each asserted request bit individually, e.g. interrupt or request-vector walkers.

Parameters:
- WIDTH, 16, input word width; legal range 1..64.
- IDX_W (localparam, not overridable), max(1, $clog2(WIDTH)), width of idx_o.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- data_i  input  WIDTH  word to serialize.
- data_val_i  input  1  data_i valid.
- data_ready_o  output  1  block can accept a word; transfer occurs when data_val_i && data_ready_o.
- idx_o  output  IDX_W  binary position of the current set bit.
- onehot_o  output  WIDTH  one-hot form of idx_o.
- idx_last_o  output  1  current beat is the highest set bit of the word.
- idx_val_o  output  1  idx_o, onehot_o and idx_last_o are valid.
- idx_ready_i  input  1  downstream accepts the beat; beat completes when idx_val_o && idx_ready_i.
- zero_o  output  1  one-cycle pulse: the accepted word was all zeros.

Behaviour:
- Reset: asynchronous assert, synchronous-release usage assumed at system level. While rst_n_i=0, outputs are:
  - data_ready_o=0, idx_val_o=0, idx_last_o=0, zero_o=0, idx_o=0, onehot_o=0.
  - Internal mask=0, state=IDLE.
- data_ready_o rises in the first clock edge after rst_n_i deasserts.
- State machine, two states:
  - IDLE: data_ready_o=1, idx_val_o=0.
    - On a transfer with data_i==0: zero_o=1 for the next cycle only, remain in IDLE.
    - On a transfer with data_i!=0: mask<=data_i, go to SER.
  - SER: data_ready_o=0, idx_val_o=1.
    - onehot_o = mask & (~mask + 1), i.e. the lowest set bit of mask. idx_o is its binary position.
    - idx_last_o = (mask with the lowest bit cleared)==0.
    - On a beat handshake: clear the lowest bit of mask. If idx_last_o=1, go to IDLE; otherwise stay in SER with the next bit.
- Outputs derive only from registered state. There is no combinational path from data_i, data_val_i or idx_ready_i to any output.
- Latency and throughput:
  - A transfer in cycle N gives idx_val_o=1 in cycle N+1.
  - With idx_ready_i held high, one beat per cycle. A word with K set bits occupies SER for exactly K cycles.
  - data_ready_o returns high in the cycle after the last beat's handshake. Minimum word-to-word period is K+1 cycles.
- Backpressure: while idx_val_o=1 and idx_ready_i=0, idx_o, onehot_o and idx_last_o hold stable.
- data_i and data_val_i are ignored outside IDLE. No buffering; the upstream must hold the word until data_ready_o.
- data_val_i with data_ready_o=0 is not an error.
- idx_ready_i is don't-care when idx_val_o=0.
- Boundary cases:
  - All-ones word produces WIDTH beats, indices 0..WIDTH-1; only the final beat has idx_last_o=1.
  - Single-bit word produces one beat with idx_last_o=1.
  - Bit WIDTH-1 alone gives idx_o=WIDTH-1.
  - WIDTH=1: IDX_W=1, idx_o always 0.
  - Non-power-of-2 WIDTH: idx_o never exceeds WIDTH-1.
- Reset mid-operation, in SER: state is discarded immediately. idx_val_o drops asynchronously and no remaining beats are emitted after release.
- zero_o and idx_val_o are never high in the same cycle.

Test Plan:
- WIDTH=8, data_i=8'b1010_0100, idx_ready_i=1:
  - idx_o sequence 2,5,7 on consecutive cycles starting 1 cycle after transfer.
  - onehot_o sequence 0x04,0x20,0x80.
  - idx_last_o high only with idx 7.
  - data_ready_o high the cycle after.
- Same word, idx_ready_i low for 3 cycles on the second beat: idx_o=5 and onehot_o=0x20 held stable for those cycles, then the sequence continues; there are no duplicate or lost beats.
- data_i=0x00 transferred: zero_o high exactly 1 cycle, idx_val_o stays 0, data_ready_o stays 1. Then data_i=0x80: single beat with idx_o=7, idx_last_o=1.
- data_i=0xFF with random idx_ready_i (50%): indices 0..7 in order, 8 handshakes total, idx_last_o only on idx 7. data_val_i is held high throughout and no second word is accepted until data_ready_o.
- rst_n_i pulsed low during beat 2 of 0xFF:
  - idx_val_o=0 and data_ready_o=0 immediately.
  - After release, data_ready_o=1 next edge with no residual beats.
  - A new word 0x01 gives a single beat with idx_o=0.
- WIDTH=5, data_i=5'b10001: beats idx 0 then 4, idx_o width 3, idx_last_o on idx 4.
